// File: rtl/rv_pkg.sv
//------------------------------------------------------------------------------
// Module   : rv_pkg
// Brief    : Shared RV32E decode constants and vector-sequencer state type.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rv_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_VEC  = 7'b1010111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } vec_state_t;

    // A single-element configuration still needs a 1-bit lane index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vec_seq_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : vec_seq_ctrl_if
// Brief    : ID-stage / lane-ALU handshake bundle for the vector sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface vec_seq_ctrl_if #(
    parameter int NUM_ELEM = 4,
    parameter int IDX_W    = rv_pkg::idx_width(NUM_ELEM),
    parameter int VL_W     = $clog2(NUM_ELEM + 1)
) ();

    logic             vld_i;
    logic [6:0]       Op_i;
    logic [VL_W-1:0]  vl_i;
    logic             lane_rdy_i;
    logic             flush_i;
    logic             stall_o;
    logic             lane_vld_o;
    logic [IDX_W-1:0] lane_idx_o;
    logic             lane_last_o;
    logic             wb_en_o;
    logic             busy_o;

    // Pipeline side: drives the instruction in ID and lane readiness.
    modport master (
        output vld_i, Op_i, vl_i, lane_rdy_i, flush_i,
        input  stall_o, lane_vld_o, lane_idx_o, lane_last_o, wb_en_o, busy_o
    );

    modport slave (
        input  vld_i, Op_i, vl_i, lane_rdy_i, flush_i,
        output stall_o, lane_vld_o, lane_idx_o, lane_last_o, wb_en_o, busy_o
    );

endinterface

`default_nettype wire

// File: rtl/vec_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module   : vec_seq_ctrl
// Brief    : Stalls ID and issues vector elements one per handshake to the lane ALU.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vec_seq_ctrl
    import rv_pkg::*;
#(
    parameter int NUM_ELEM = 4,
    parameter int IDX_W    = idx_width(NUM_ELEM),
    parameter int VL_W     = $clog2(NUM_ELEM + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    vec_seq_ctrl_if.slave bus
);

    vec_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VL_W-1:0]  vl_len_q, vl_len_d;

    logic             w_accept;
    logic [VL_W-1:0]  w_vl_clamp;
    logic             w_last;
    logic             w_handshake;

    logic             stall;
    logic             lane_vld;
    logic [IDX_W-1:0] lane_idx;
    logic             lane_last;
    logic             wb_en;
    logic             busy;

    assign w_accept    = (state_q == IDLE) && bus.vld_i && (bus.Op_i == OP_VEC) && !bus.flush_i;
    assign w_vl_clamp  = (bus.vl_i > VL_W'(NUM_ELEM)) ? VL_W'(NUM_ELEM) : bus.vl_i;
    assign w_last      = (VL_W'(idx_q) == (vl_len_q - VL_W'(1)));
    assign w_handshake = (state_q == RUN) && bus.lane_rdy_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            vl_len_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            vl_len_q <= vl_len_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        vl_len_d = vl_len_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    vl_len_d = w_vl_clamp;
                    idx_d    = '0;
                    state_d  = (w_vl_clamp != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // A flush discards the element even if the lane takes it this cycle.
                if (bus.flush_i) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (w_handshake) begin
                    if (w_last) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall     = w_accept || (state_q == RUN);
        lane_vld  = (state_q == RUN);
        lane_idx  = (state_q == RUN) ? idx_q : '0;
        lane_last = (state_q == RUN) && w_last;
        wb_en     = (state_q == DONE) && (vl_len_q != '0) && !bus.flush_i;
        busy      = (state_q != IDLE);
    end

    assign bus.stall_o     = stall;
    assign bus.lane_vld_o  = lane_vld;
    assign bus.lane_idx_o  = lane_idx;
    assign bus.lane_last_o = lane_last;
    assign bus.wb_en_o     = wb_en;
    assign bus.busy_o      = busy;

endmodule

`default_nettype wire
